// File: rtl/srlz_pkg.sv
// srlz_pkg: state encoding and bit-order constant shared by both ends of the serial link.
package srlz_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} srlz_state_e;
   localparam bit SRLZ_MSB_FIRST = 1'b1;
endpackage

// File: rtl/srlz_out_buf.sv
// srlz_out_buf: output holding register with valid/ready handshake and sticky overrun.
// DESRLZ_PARITY_EN adds a parity_err flag registered alongside dout.
module srlz_out_buf #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  commit,
   input  logic [DATA_WIDTH-1:0] cdata,
`ifdef DESRLZ_PARITY_EN
   input  logic                  cperr,
   output logic                  parity_err,
`endif
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  overrun
);
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic valid_q, valid_d, ovr_q, ovr_d, free, take;
`ifdef DESRLZ_PARITY_EN
   logic perr_q, perr_d;
   assign parity_err = perr_q;
`endif
   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;
   always_comb begin
      free    = !valid_q || dout_ready;
      take    = commit && free;
      dout_d  = take ? cdata : dout_q;
      valid_d = take || (valid_q && !dout_ready);
      ovr_d   = ovr_q || (commit && !free);
`ifdef DESRLZ_PARITY_EN
      perr_d  = take ? cperr : perr_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef DESRLZ_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef DESRLZ_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end
endmodule

// File: rtl/desrlz_sipo.sv
// desrlz_sipo: MSB-first serial-in/parallel-out deserializer with frame alignment.
// DESRLZ_PARITY_EN appends one even-parity bit per word and exposes parity_err.
module desrlz_sipo
   import srlz_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sin,
   input  logic                  sin_en,
   input  logic                  frame,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  overrun
`ifdef DESRLZ_PARITY_EN
  ,output logic                  parity_err
`endif
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   srlz_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sr_q, sr_d, shifted, cdata;
   logic commit;
`ifdef DESRLZ_PARITY_EN
   logic cperr;
`endif
   always_comb begin
      shifted = SRLZ_MSB_FIRST ? {sr_q[DATA_WIDTH-2:0], sin} : {sin, sr_q[DATA_WIDTH-1:1]};
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      commit  = 1'b0;
`ifdef DESRLZ_PARITY_EN
      cdata   = sr_q;
      cperr   = ^sr_q ^ sin;
`else
      cdata   = shifted;
`endif
      // a framed strobe always starts a fresh word, dropping any partial one
      if (sin_en && frame) begin
         state_d = SHIFT;
         cnt_d   = CW'(1);
         sr_d    = SRLZ_MSB_FIRST ? DATA_WIDTH'(sin) : {sin, {(DATA_WIDTH-1){1'b0}}};
      end else if (sin_en && state_q == SHIFT) begin
         sr_d = shifted;
         if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef DESRLZ_PARITY_EN
            state_d = PAR;
            cnt_d   = CW'(DATA_WIDTH);
`else
            state_d = IDLE;
            cnt_d   = '0;
            commit  = 1'b1;
`endif
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
`ifdef DESRLZ_PARITY_EN
      else if (sin_en && state_q == PAR) begin
         state_d = IDLE;
         cnt_d   = '0;
         commit  = 1'b1;
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end
   srlz_out_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .commit     (commit),
      .cdata      (cdata),
`ifdef DESRLZ_PARITY_EN
      .cperr      (cperr),
      .parity_err (parity_err),
`endif
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .overrun    (overrun)
   );
endmodule

// File: tb/tb_desrlz_sipo.sv
// tb_desrlz_sipo: directed table-driven bench for desrlz_sipo (DATA_WIDTH=8).
// Honours DESRLZ_PARITY_EN by appending parity bits and checking parity_err.
module tb_desrlz_sipo;
   import srlz_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, sin = 1'b0, sin_en = 1'b0, frame = 1'b0, dout_ready = 1'b1;
   logic [7:0] dout;
   logic dout_valid, overrun;
`ifdef DESRLZ_PARITY_EN
   logic parity_err;
`endif
   int errors = 0, checks = 0, acc = 0;

   desrlz_sipo #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
      .sin_en     (sin_en),
      .frame      (frame),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun)
`ifdef DESRLZ_PARITY_EN
     ,.parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (rst_n && dout_valid && dout_ready) acc <= acc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // all stimulus tasks start and end just after a falling edge
   task automatic strobe(input logic b, input logic f);
      sin = b; sin_en = 1'b1; frame = f;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      sin_en = 1'b0; frame = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] w, input int gap, input logic p);
      for (int i = 0; i < 8; i++) begin
         strobe(w[7-i], i == 0);
`ifdef DESRLZ_PARITY_EN
         idle(gap);
`else
         if (i != 7) idle(gap);
`endif
      end
`ifdef DESRLZ_PARITY_EN
      strobe(p, 1'b0);
`else
      if (p) sin = 1'b0;
`endif
   endtask

   task automatic do_reset;
      rst_n = 1'b0; sin = 1'b1; sin_en = 1'b1; frame = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; sin_en = 1'b0;
   endtask

   typedef struct {
      logic [7:0] w;
      int         gap;
   } vec_t;
   vec_t v[7];

   initial begin
      v[0] = '{8'hA5, 0};
      v[1] = '{8'hA5, 2};
      v[2] = '{8'h3C, 0};
      v[3] = '{8'hFF, 1};
      v[4] = '{8'h00, 0};
      v[5] = '{8'h01, 0};
      v[6] = '{8'h80, 3};
      @(negedge clk);
      do_reset();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_state", dut.state_q, IDLE);
      chk("rst_cnt", dut.cnt_q, 0);
`ifdef DESRLZ_PARITY_EN
      chk("rst_perr", parity_err, 0);
`endif
      for (int k = 0; k < 7; k++) begin
         do_reset();
         acc = 0;
         dout_ready = 1'b1;
         send_word(v[k].w, v[k].gap, ^v[k].w);
         chk($sformatf("vec%0d_valid", k), dout_valid, 1);
         chk($sformatf("vec%0d_dout", k), dout, v[k].w);
`ifdef DESRLZ_PARITY_EN
         chk($sformatf("vec%0d_perr", k), parity_err, 0);
`endif
         idle(1);
         chk($sformatf("vec%0d_drop", k), dout_valid, 0);
         idle(4);
         chk($sformatf("vec%0d_words", k), acc, 1);
         chk($sformatf("vec%0d_ovr", k), overrun, 0);
      end
      // stray bits without frame and frame without strobe are ignored
      do_reset();
      acc = 0;
      for (int i = 0; i < 10; i++) strobe(1'b1, 1'b0);
      sin_en = 1'b0; frame = 1'b1;
      repeat (3) @(negedge clk);
      idle(1);
      chk("ignore_valid", dout_valid, 0);
      chk("ignore_state", dut.state_q, IDLE);
      send_word(8'h96, 0, 1'b0);
      chk("ignore_dout", dout, 8'h96);
      idle(3);
      chk("ignore_words", acc, 1);
      // backpressure and sticky overrun
      do_reset();
      dout_ready = 1'b0;
      send_word(8'h3C, 0, 1'b0);
      chk("bp_valid1", dout_valid, 1);
      chk("bp_dout1", dout, 8'h3C);
      chk("bp_ovr1", overrun, 0);
      send_word(8'hC3, 1, 1'b0);
      chk("bp_dout2", dout, 8'h3C);
      chk("bp_ovr2", overrun, 1);
      chk("bp_valid2", dout_valid, 1);
      idle(1);
      dout_ready = 1'b1;
      @(negedge clk);
      chk("bp_drop", dout_valid, 0);
      chk("bp_ovr_sticky", overrun, 1);
      // back-to-back words with strobe held high
      do_reset();
      acc = 0;
      send_word(8'h3C, 0, 1'b0);
      chk("b2b_dout1", dout, 8'h3C);
      send_word(8'hC3, 0, 1'b1);
      chk("b2b_dout2", dout, 8'hC3);
      chk("b2b_valid2", dout_valid, 1);
      idle(3);
      chk("b2b_words", acc, 2);
      chk("b2b_ovr", overrun, 0);
      // resync after 4 bits
      do_reset();
      acc = 0;
      strobe(1'b1, 1'b1); strobe(1'b1, 1'b0); strobe(1'b1, 1'b0); strobe(1'b1, 1'b0);
      send_word(8'h5A, 0, 1'b0);
      chk("resync_dout", dout, 8'h5A);
      chk("resync_valid", dout_valid, 1);
      idle(4);
      chk("resync_words", acc, 1);
      chk("resync_ovr", overrun, 0);
      // reset mid-word
      do_reset();
      acc = 0;
      strobe(1'b0, 1'b1); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0); strobe(1'b0, 1'b0);
      do_reset();
      chk("midrst_cnt", dut.cnt_q, 0);
      send_word(8'hFF, 0, 1'b0);
      chk("midrst_dout", dout, 8'hFF);
      idle(4);
      chk("midrst_words", acc, 1);
      // reset while a word is held
      dout_ready = 1'b0;
      send_word(8'h77, 0, 1'b0);
      idle(1);
      do_reset();
      chk("heldrst_valid", dout_valid, 0);
      chk("heldrst_dout", dout, 0);
      dout_ready = 1'b1;
`ifdef DESRLZ_PARITY_EN
      do_reset();
      send_word(8'hA5, 0, 1'b1);
      chk("par1_dout", dout, 8'hA5);
      chk("par1_err", parity_err, 1);
      send_word(8'hA5, 0, 1'b0);
      chk("par0_dout", dout, 8'hA5);
      chk("par0_err", parity_err, 0);
      send_word(8'h01, 0, 1'b0);
      chk("par01_err", parity_err, 1);
      idle(2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
